// File: rtl/cpu_ibus_if.sv
// Instruction bus between the fetch unit (master) and the 2-stage I$ (slave).
interface cpu_ibus_if;
  logic        read;
  logic [31:0] address;
  logic        flush_1;
  logic        flush_2;
  logic        stall;
  logic        valid;
  logic [63:0] rddata;

  modport master (
    output read, address, flush_1, flush_2,
    input  stall, valid, rddata
  );
  modport slave (
    input  read, address, flush_1, flush_2,
    output stall, valid, rddata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch front end: issues 8-byte I$ reads, unpacks 64-bit lines into an instruction FIFO.
// Optional IFU_ADDR_ERR_EN: misaligned redirect targets enqueue one address-error marker.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'hBFC00000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  cpu_ibus_if.master  ibus,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_addr_err,
  input  logic        instr_ready
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [31:0]   r_pc;
  logic [1:0]    r_inflight;
  logic          r_tag_wr;
  logic          r_tag_rd;
  logic [31:0]   r_tag_pc [2];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          r_err_lock;
  logic [31:0]   r_fifo_instr [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc    [FIFO_DEPTH];

  logic [PW-1:0] w_count;
  logic [31:0]   w_free;
  logic [31:0]   w_need;
  logic          w_credit;
  logic          w_accept;
  logic          w_resp;
  logic          w_pop;
  logic          w_misaligned;
  logic [31:0]   w_resp_pc;
  logic [AW-1:0] w_rd_idx;
  logic          w_wr0_en;
  logic          w_wr1_en;
  logic [AW-1:0] w_wr0_idx;
  logic [AW-1:0] w_wr1_idx;
  logic [31:0]   w_wr0_instr;
  logic [31:0]   w_wr0_pc;
  logic          w_wr0_err;
  logic [1:0]    w_push_n;

`ifdef IFU_ADDR_ERR_EN
  logic r_fifo_err [FIFO_DEPTH];
  assign w_misaligned   = (redirect_pc[1:0] != 2'b00);
  assign instr_addr_err = instr_valid & r_fifo_err[w_rd_idx];
`else
  assign w_misaligned   = 1'b0;
  assign instr_addr_err = 1'b0;
`endif

  // Reserve room for every outstanding line so a response always fits.
  assign w_count  = r_wptr - r_rptr;
  assign w_free   = FIFO_DEPTH - 32'(w_count);
  assign w_need   = {29'd0, r_inflight, 1'b0} + 32'd2;
  assign w_credit = (r_inflight < 2'd2) && (w_free >= w_need);

  assign ibus.read    = !rst && !redirect_valid && !r_err_lock && w_credit;
  assign ibus.address = {r_pc[31:3], 3'b000};
  assign ibus.flush_1 = redirect_valid;
  assign ibus.flush_2 = redirect_valid;

  assign w_accept  = ibus.read && !ibus.stall;
  assign w_resp    = ibus.valid && !ibus.stall && !redirect_valid && (r_inflight != 2'd0);
  assign w_resp_pc = r_tag_pc[r_tag_rd];

  assign w_rd_idx    = r_rptr[AW-1:0];
  assign instr_valid = (r_wptr != r_rptr);
  assign instr       = instr_valid ? r_fifo_instr[w_rd_idx] : '0;
  assign instr_pc    = instr_valid ? r_fifo_pc[w_rd_idx] : '0;
  assign w_pop       = instr_valid && instr_ready && !redirect_valid;

  always_comb begin
    w_wr0_en    = 1'b0;
    w_wr1_en    = 1'b0;
    w_wr0_idx   = r_wptr[AW-1:0];
    w_wr1_idx   = r_wptr[AW-1:0] + AW'(1);
    w_wr0_instr = ibus.rddata[31:0];
    w_wr0_pc    = w_resp_pc;
    w_wr0_err   = 1'b0;
    w_push_n    = 2'd0;
    if (redirect_valid) begin
      if (w_misaligned) begin
        w_wr0_en    = 1'b1;
        w_wr0_idx   = '0;
        w_wr0_instr = '0;
        w_wr0_pc    = redirect_pc;
        w_wr0_err   = 1'b1;
      end
    end else if (w_resp) begin
      w_wr0_en = 1'b1;
      // Odd-word fetch target: only the upper half of the line is wanted.
      if (w_resp_pc[2]) begin
        w_wr0_instr = ibus.rddata[63:32];
        w_push_n    = 2'd1;
      end else begin
        w_wr1_en = 1'b1;
        w_push_n = 2'd2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= 2'd0;
      r_tag_wr   <= 1'b0;
      r_tag_rd   <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_err_lock <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= {redirect_pc[31:2], 2'b00};
      r_inflight <= 2'd0;
      r_tag_wr   <= 1'b0;
      r_tag_rd   <= 1'b0;
      r_rptr     <= '0;
      r_wptr     <= w_misaligned ? PW'(1) : '0;
      r_err_lock <= w_misaligned;
    end else begin
      if (w_accept) begin
        r_pc     <= {r_pc[31:3], 3'b000} + 32'd8;
        r_tag_wr <= ~r_tag_wr;
      end
      if (w_resp) r_tag_rd <= ~r_tag_rd;
      r_inflight <= r_inflight + 2'(w_accept) - 2'(w_resp);
      r_wptr     <= r_wptr + PW'(w_push_n);
      if (w_pop) r_rptr <= r_rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_tag_pc[r_tag_wr] <= r_pc;
    if (w_wr0_en) begin
      r_fifo_instr[w_wr0_idx] <= w_wr0_instr;
      r_fifo_pc[w_wr0_idx]    <= w_wr0_pc;
    end
    if (w_wr1_en) begin
      r_fifo_instr[w_wr1_idx] <= ibus.rddata[63:32];
      r_fifo_pc[w_wr1_idx]    <= w_resp_pc + 32'd4;
    end
`ifdef IFU_ADDR_ERR_EN
    if (w_wr0_en) r_fifo_err[w_wr0_idx] <= w_wr0_err;
    if (w_wr1_en) r_fifo_err[w_wr1_idx] <= 1'b0;
`endif
  end

endmodule
